clock_freq_divider: RTL and testbench
=====================================

// Module: clock_freq_divider
// PURPOSE
// - Divides the board clock down to a visible LED blink rate (LED blinker top-level helper).
// - A free-running terminal-count counter A drives a toggle flop on led.
// - At 100 MHz clk with defaults: led toggles every 1 s, giving a 0.5 Hz square wave.
// - A is exported for debug and for observation by the testbench.
// PARAMETERS
// - WIDTH        27           counter width in bits; sets the width of port A
// - HALF_PERIOD  100_000_000  clk cycles per led level; legal range 1 .. 2**WIDTH
// PORTS
// - clk    in   1      system clock; all logic on its rising edge
// - reset  in   1      synchronous, active-high reset
// - led    out  1      divided clock / LED drive; registered output
// - A      out  WIDTH  current counter value; registered output
// BEHAVIOUR
// - Interface: one clock (clk); reset is synchronous and active-high.
// - Reset: at a rising clk edge with reset=1, A <= 0 and led <= 0.
//   - reset overrides all counting.
//   - Asserting reset mid-count aborts the count; no partial toggle occurs.
//   - Before the first reset edge, the values of A and led are undefined.
// - Counting: each rising edge with reset=0:
//   - if A == HALF_PERIOD-1: A <= 0 and led <= ~led (terminal event)
//   - else: A <= A+1 and led holds
// - Range: A always stays in 0 .. HALF_PERIOD-1, so A never wraps at 2**WIDTH.
//   - The comparison uses the full WIDTH bits, with unsigned arithmetic.
// - Timing: the first toggle comes HALF_PERIOD edges after the reset edge is released.
//   - After that, led toggles every HALF_PERIOD cycles.
//   - led period = 2*HALF_PERIOD cycles, duty cycle exactly 50%.
// - Boundary case HALF_PERIOD=1: A stays at 0, and led toggles on every edge (clk/2).
// - Boundary case HALF_PERIOD=2**WIDTH: terminal value is all ones, so A runs the full range.
// - Outputs are driven directly from flops; there are no combinational paths from inputs.
// - No handshake; no other inputs.
// - Elaboration: HALF_PERIOD outside 1 .. 2**WIDTH is a fatal error (generate-time check).
// TESTING
// - Reset: clk 10 ns period, reset=1 for the first edge -> A=0, led=0.
//   - With reset held for 5 edges, A stays 0 and led stays 0 throughout.
// - Count/toggle, HALF_PERIOD=5: release reset.
//   - A steps 1,2,3,4,0 over 5 edges.
//   - led goes 1 on the 5th edge, 0 on the 10th edge, and so on.
//   - led period = 10 cycles = 100 ns.
// - Mid-count reset, HALF_PERIOD=5: assert reset for 1 edge when A=3 and led=1.
//   - A=0 and led=0 on the next edge.
//   - The next toggle (led=1) comes 5 edges after release.
// - Minimum divide, HALF_PERIOD=1: A stays 0, and led alternates 1,0,1,... each edge.
// - Default parameters, 100 MHz: after release, led=0 up to 100_000_000 edges.
//   - led rises exactly at edge 100_000_000, when A=99_999_999 -> 0.
//   - A never exceeds 99_999_999, and it fits in 27 bits.
// - Full range, WIDTH=4, HALF_PERIOD=16: A counts 0..15 and then returns to 0.
//   - led toggles only on the 15 -> 0 transition.

Source files
------------

// File: rtl/clock_freq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : clock_freq_divider
//  Description : LED blink-rate divider. A free-running terminal-count
//                counter (A) wraps every HALF_PERIOD clk cycles. Each wrap
//                toggles the led flop, so led is a 50% duty square wave
//                with a period of 2*HALF_PERIOD clk cycles.
//  Ports       : clk   - system clock, rising edge
//                reset - synchronous, active-high reset
//                led   - divided clock / LED drive (registered)
//                A     - current counter value, exported for debug (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_freq_divider #(
  parameter int unsigned     WIDTH       = 27,
  parameter longint unsigned HALF_PERIOD = 100_000_000
) (
  input  logic             clk,
  input  logic             reset,
  output logic             led,
  output logic [WIDTH-1:0] A
);

  // Largest legal HALF_PERIOD is 2**WIDTH, which does not fit in WIDTH bits,
  // so the range check is done in 64-bit arithmetic.
  localparam longint unsigned c_MAX_HALF_PERIOD = 64'd1 << WIDTH;

  // Terminal count. With HALF_PERIOD == 2**WIDTH this truncates to all ones,
  // letting the counter run the full range without ever wrapping by overflow.
  localparam logic [WIDTH-1:0] c_TERM = WIDTH'(HALF_PERIOD - 64'd1);

  generate
    if (WIDTH < 1 || WIDTH > 63) begin : g_bad_width
      $fatal(1, "clock_freq_divider: WIDTH must be in 1..63");
    end
    if (HALF_PERIOD < 64'd1 || HALF_PERIOD > c_MAX_HALF_PERIOD) begin : g_bad_half_period
      $fatal(1, "clock_freq_divider: HALF_PERIOD must be in 1..2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] r_count;
  logic             r_led;
  logic             w_terminal;

  // Full-width unsigned compare against the terminal value.
  assign w_terminal = (r_count == c_TERM);

  // Reset wins over counting, so a mid-count reset never produces a toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_led   <= 1'b0;
    end else if (w_terminal) begin
      r_count <= '0;
      r_led   <= ~r_led;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign led = r_led;
  assign A   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_clock_freq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_freq_divider
//  Description : Testbench for clock_freq_divider. Four instances with
//                different WIDTH/HALF_PERIOD share one clock and reset.
//                The reference model tracks only the number of counting
//                edges since the last reset edge (n); the expected counter
//                value is n mod HALF_PERIOD and the expected led level is
//                floor(n / HALF_PERIOD) mod 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_freq_divider;

  logic clk;
  logic reset;

  logic       led_hp5,  led_hp1,  led_full, led_hp7;
  logic [7:0] A_hp5;
  logic [3:0] A_hp1;
  logic [3:0] A_full;
  logic [2:0] A_hp7;

  clock_freq_divider #(.WIDTH(8), .HALF_PERIOD(5)) u_hp5 (
    .clk(clk), .reset(reset), .led(led_hp5), .A(A_hp5)
  );
  clock_freq_divider #(.WIDTH(4), .HALF_PERIOD(1)) u_hp1 (
    .clk(clk), .reset(reset), .led(led_hp1), .A(A_hp1)
  );
  clock_freq_divider #(.WIDTH(4), .HALF_PERIOD(16)) u_full (
    .clk(clk), .reset(reset), .led(led_full), .A(A_full)
  );
  clock_freq_divider #(.WIDTH(3), .HALF_PERIOD(7)) u_hp7 (
    .clk(clk), .reset(reset), .led(led_hp7), .A(A_hp7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass   = 0;
  longint n_edges  = 0;  // counting edges since the last reset edge

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [63:0] exp_a(input longint hp);
    return 64'(n_edges % hp);
  endfunction

  function automatic logic [63:0] exp_led(input longint hp);
    return 64'((n_edges / hp) % 2);
  endfunction

  task automatic check_all();
    chk("hp5.A",    64'(A_hp5),    exp_a(5));
    chk("hp5.led",  64'(led_hp5),  exp_led(5));
    chk("hp1.A",    64'(A_hp1),    exp_a(1));
    chk("hp1.led",  64'(led_hp1),  exp_led(1));
    chk("full.A",   64'(A_full),   exp_a(16));
    chk("full.led", 64'(led_full), exp_led(16));
    chk("hp7.A",    64'(A_hp7),    exp_a(7));
    chk("hp7.led",  64'(led_hp7),  exp_led(7));
  endtask

  // One clock edge with the given reset level, then sample 1 ns later.
  task automatic step(input logic rst_v);
    @(negedge clk);
    reset = rst_v;
    @(posedge clk);
    if (rst_v) n_edges = 0;
    else       n_edges = n_edges + 1;
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1;

    // Reset held for 5 edges: everything stays at zero.
    for (int i = 0; i < 5; i++) step(1'b1);

    // Release and run until the HP=5 instance sits at A=3, led=1 (n=8).
    for (int i = 0; i < 8; i++) step(1'b0);
    chk("hp5.pre_abort.A",   64'(A_hp5),   64'd3);
    chk("hp5.pre_abort.led", 64'(led_hp5), 64'd1);

    // Mid-count abort, then the next toggle must be 5 edges after release.
    step(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0);
    chk("hp5.post_abort.led", 64'(led_hp5), 64'd1);

    // Long run covering several full periods of every instance.
    for (int i = 0; i < 60; i++) step(1'b0);

    // Randomized reset pulses over a longer stretch.
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 39) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a stalled simulation.
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
